// File: rtl/seg_scan_display_if.sv
// Bundles the load/data inputs and the display drive outputs of seg_scan_display.
interface seg_scan_display_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  neg_in;
    logic                  err_in;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  upd_done;
    logic                  pending;

    modport master (
        output load, bcd_in, neg_in, err_in,
        input  seg, an, upd_done, pending
    );

    modport slave (
        input  load, bcd_in, neg_in, err_in,
        output seg, an, upd_done, pending
    );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: double-buffered BCD value with frame-aligned
// commit, leading-zero blanking, minus sign placement and an "Err" pattern.
module seg_scan_display #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int LZ_BLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_display_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int BW = 4 * DIGITS;

    logic [PW-1:0] pcnt;
    logic [IW-1:0] idx;
    logic          tick;
    logic          frame;
    logic [BW-1:0] sh_bcd, act_bcd;
    logic          sh_neg, sh_err, act_neg, act_err;
    logic          pending_q, upd_q;
    logic [6:0]    seg_d;

    assign tick  = (pcnt == PW'(SCAN_DIV - 1));
    assign frame = tick && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            idx       <= '0;
            // NOTE: the data registers are reset too, because reset must blank the display
            // and throw away any value still waiting in the shadow.
            sh_bcd    <= '1;
            sh_neg    <= 1'b0;
            sh_err    <= 1'b0;
            act_bcd   <= '1;
            act_neg   <= 1'b0;
            act_err   <= 1'b0;
            pending_q <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

            // Commit uses the shadow as it was before this edge, so a load on the
            // boundary cycle is held back for the following frame.
            upd_q <= frame && pending_q;
            if (frame && pending_q) begin
                act_bcd <= sh_bcd;
                act_neg <= sh_neg;
                act_err <= sh_err;
            end

            if (bus.load) begin
                sh_bcd    <= bus.bcd_in;
                sh_neg    <= bus.neg_in;
                sh_err    <= bus.err_in;
                pending_q <= 1'b1;
            end else if (frame) begin
                pending_q <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        logic [DIGITS-1:0] blank;
        logic              zero_run;
        logic              show_err;
        int                top;
        int                minus_pos;

        // NOTE: every variable gets a value before any conditional use, so no latch is inferred.
        blank    = '0;
        zero_run = 1'b1;
        top      = -1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_bcd[4*k +: 4] == 4'd0);
            blank[k] = (act_bcd[4*k +: 4] > 4'd9) || ((LZ_BLANK == 1) && (k > 0) && zero_run);
            if (!blank[k] && (top < 0)) top = k;
        end
        // The sign goes directly above the most significant visible digit.
        minus_pos = top + 1;
        show_err  = act_err || (act_neg && (minus_pos >= DIGITS));

        seg_d = 7'h7F;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                if (show_err)
                    seg_d = (k == 2) ? 7'h06 : ((k < 2) ? 7'h2F : 7'h7F);
                else if (act_neg && (k == minus_pos))
                    seg_d = 7'h3F;
                else if (blank[k])
                    seg_d = 7'h7F;
                else
                    seg_d = bcd_to_seg(act_bcd[4*k +: 4]);
            end
        end
    end

    assign bus.seg      = seg_d;
    assign bus.an       = ~(DIGITS'(1) << idx);
    assign bus.upd_done = upd_q;
    assign bus.pending  = pending_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (DIGITS=4, SCAN_DIV=4, LZ_BLANK=1): a frame-level
// model checked every cycle, plus hand-computed display snapshots.
module tb_seg_scan_display;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seg_scan_display_if #(.DIGITS(4)) bus ();

    seg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .LZ_BLANK(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected segments of digit k, straight from the display rules.
    function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic neg,
                                           input logic err, input int k);
        int d[4];
        bit blk[4];
        int top;
        top = -1;
        for (int j = 0; j < 4; j++) begin
            d[j]   = int'((v >> (4 * j)) & 16'hF);
            blk[j] = (d[j] > 9) || ((j > 0) && ((v >> (4 * j)) == 16'h0));
            if (!blk[j]) top = j;
        end
        if (err || (neg && (top + 1 > 3))) return (k == 2) ? 7'h06 : ((k < 2) ? 7'h2F : 7'h7F);
        if (neg && (k == top + 1)) return 7'h3F;
        if (blk[k]) return 7'h7F;
        case (d[k])
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    function automatic logic [3:0] an_for(input int slot);
        case (slot)
            0: return 4'hE;
            1: return 4'hD;
            2: return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    // Model: one frame is 16 cycles; cycle 15 of each frame is the boundary.
    int          m_cyc;
    logic [15:0] m_sh, m_act;
    logic        m_sh_neg, m_sh_err, m_act_neg, m_act_err, m_pend, m_upd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0;
            m_sh <= 16'hFFFF; m_sh_neg <= 1'b0; m_sh_err <= 1'b0;
            m_act <= 16'hFFFF; m_act_neg <= 1'b0; m_act_err <= 1'b0;
            m_pend <= 1'b0; m_upd <= 1'b0;
        end else begin
            bit boundary;
            boundary = ((m_cyc % 16) == 15);
            m_upd <= boundary && m_pend;
            if (boundary && m_pend) begin
                m_act <= m_sh; m_act_neg <= m_sh_neg; m_act_err <= m_sh_err;
            end
            if (bus.load) begin
                m_sh <= bus.bcd_in; m_sh_neg <= bus.neg_in; m_sh_err <= bus.err_in;
                m_pend <= 1'b1;
            end else if (boundary) begin
                m_pend <= 1'b0;
            end
            m_cyc <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        int slot;
        slot = (m_cyc / 4) % 4;
        check("cyc_seg", 32'(bus.seg), 32'(exp_seg(m_act, m_act_neg, m_act_err, slot)));
        check("cyc_an", 32'(bus.an), 32'(an_for(slot)));
        check("cyc_pending", 32'(bus.pending), 32'(m_pend));
        check("cyc_upd_done", 32'(bus.upd_done), 32'(m_upd));
    end

    task automatic do_load(input logic [15:0] v, input logic n, input logic e);
        @(negedge clk); #2;
        bus.bcd_in = v; bus.neg_in = n; bus.err_in = e; bus.load = 1'b1;
        @(negedge clk); #2;
        bus.load = 1'b0;
    endtask

    task automatic wait_upd(input string name);
        int n;
        n = 0;
        while (bus.upd_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.upd_done), 32'd1);
    endtask

    task automatic show(input string name, input int k, input logic [6:0] exp);
        int n;
        n = 0;
        while (bus.an !== an_for(k) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_an"}, 32'(bus.an), 32'(an_for(k)));
        check(name, 32'(bus.seg), 32'(exp));
    endtask

    initial begin
        logic [3:0] an_seq [4];
        int n;
        an_seq = '{4'hE, 4'hD, 4'hB, 4'h7};
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.load = 1'b0; bus.bcd_in = 16'h0; bus.neg_in = 1'b0; bus.err_in = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_an", 32'(bus.an), 32'h0000_000E);
        check("rst_seg", 32'(bus.seg), 32'h0000_007F);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_upd", 32'(bus.upd_done), 32'd0);
        #1 rst_n = 1'b1;

        // Blank scan after reset
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("scan_an", 32'(bus.an), 32'(an_seq[(i / 4) % 4]));
            check("scan_seg", 32'(bus.seg), 32'h0000_007F);
        end

        do_load(16'h0042, 1'b0, 1'b0);
        check("p42_pending", 32'(bus.pending), 32'd1);
        wait_upd("p42_upd");
        @(negedge clk);
        check("p42_upd_once", 32'(bus.upd_done), 32'd0);
        check("p42_pending_clr", 32'(bus.pending), 32'd0);
        show("p42_d0", 0, 7'h24);
        show("p42_d1", 1, 7'h19);
        show("p42_d2", 2, 7'h7F);
        show("p42_d3", 3, 7'h7F);

        do_load(16'h0042, 1'b1, 1'b0);
        wait_upd("n42_upd");
        show("n42_d0", 0, 7'h24);
        show("n42_d1", 1, 7'h19);
        show("n42_d2", 2, 7'h3F);
        show("n42_d3", 3, 7'h7F);

        do_load(16'h1234, 1'b1, 1'b0);
        wait_upd("n1234_upd");
        show("n1234_d0", 0, 7'h2F);
        show("n1234_d1", 1, 7'h2F);
        show("n1234_d2", 2, 7'h06);
        show("n1234_d3", 3, 7'h7F);

        do_load(16'h0A05, 1'b1, 1'b0);
        wait_upd("na05_upd");
        show("na05_d0", 0, 7'h12);
        show("na05_d1", 1, 7'h40);
        show("na05_d2", 2, 7'h3F);
        show("na05_d3", 3, 7'h7F);

        // Further patterns covered by the per-cycle model only
        do_load(16'h0042, 1'b0, 1'b1);
        wait_upd("err_upd");
        repeat (16) @(negedge clk);
        do_load(16'h0000, 1'b1, 1'b0);
        wait_upd("neg0_upd");
        repeat (16) @(negedge clk);
        do_load(16'h0000, 1'b0, 1'b0);
        wait_upd("zero_upd");
        repeat (16) @(negedge clk);
        do_load(16'h9807, 1'b0, 1'b0);
        wait_upd("full_upd");
        repeat (16) @(negedge clk);

        // Last load wins, and a load on the boundary waits one more frame
        n = 0;
        while ((m_cyc % 16) != 3 && n < 40) begin @(negedge clk); n++; end
        do_load(16'h0001, 1'b0, 1'b0);
        do_load(16'h0009, 1'b0, 1'b0);
        n = 0;
        while ((m_cyc % 16) != 15 && n < 40) begin @(negedge clk); n++; end
        #2;
        bus.bcd_in = 16'h0007; bus.neg_in = 1'b0; bus.err_in = 1'b0; bus.load = 1'b1;
        @(negedge clk);
        check("coll_upd", 32'(bus.upd_done), 32'd1);
        check("coll_pending", 32'(bus.pending), 32'd1);
        #2 bus.load = 1'b0;
        show("coll_d0_nine", 0, 7'h10);
        @(negedge clk);
        wait_upd("coll_next_upd");
        show("coll_d0_seven", 0, 7'h78);
        check("coll_pending_clr", 32'(bus.pending), 32'd0);

        // Reset mid-slot with data pending
        do_load(16'h0055, 1'b0, 1'b0);
        check("mrst_pending_before", 32'(bus.pending), 32'd1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mrst_an", 32'(bus.an), 32'h0000_000E);
        check("mrst_seg", 32'(bus.seg), 32'h0000_007F);
        check("mrst_pending", 32'(bus.pending), 32'd0);
        check("mrst_upd", 32'(bus.upd_done), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.upd_done === 1'b1) n++;
        end
        check("mrst_no_upd", 32'(n), 32'd0);

        // Load in the very first cycle after reset release
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1;
        bus.bcd_in = 16'h0003; bus.neg_in = 1'b0; bus.err_in = 1'b0; bus.load = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        #2 bus.load = 1'b0;
        check("first_pending", 32'(bus.pending), 32'd1);
        wait_upd("first_upd");
        show("first_d0", 0, 7'h30);
        show("first_d1", 1, 7'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
